// File: rtl/instruction_fetch_if.sv
// Bundles the fetch stage's memory, redirect/resume and decode handshake signals.
// master = fetch stage, slave = the surrounding memory/decoder/control side.
interface instruction_fetch_if;
  logic [31:0] instruction_address;
  logic [31:0] instruction_data_input;
  logic        redirect_valid;
  logic [31:0] redirect_address;
  logic        resume;
  logic        decode_ready;
  logic        fetched_valid;
  logic [31:0] fetched_instruction;
  logic [31:0] fetched_pc;
  logic        halted;

  modport master (
    output instruction_address,
    input  instruction_data_input,
    input  redirect_valid,
    input  redirect_address,
    input  resume,
    input  decode_ready,
    output fetched_valid,
    output fetched_instruction,
    output fetched_pc,
    output halted
  );

  modport slave (
    input  instruction_address,
    output instruction_data_input,
    output redirect_valid,
    output redirect_address,
    output resume,
    output decode_ready,
    input  fetched_valid,
    input  fetched_instruction,
    input  fetched_pc,
    input  halted
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, capture of the combinationally read memory word into
// the fetch/decode register, with warm-up, backpressure, redirect/flush and halt.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter logic [4:0]  HALT_OPCODE = 5'b00110,
  parameter int          START_DELAY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  instruction_fetch_if.master   bus
);

  typedef enum logic [1:0] {WARMUP, FETCH, HALTED} state_t;

  localparam int CW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [CW-1:0] WARM_LAST = CW'(START_DELAY - 1);

  state_t      state;
  logic [CW-1:0] warm_count;
  logic [31:0] pc;
  logic        fetched_valid_q;
  logic [31:0] fetched_instruction_q;
  logic [31:0] fetched_pc_q;
  logic        halted_q;

  logic capture_ok;
  assign capture_ok = !fetched_valid_q || bus.decode_ready;

  assign bus.instruction_address  = pc;
  assign bus.fetched_valid        = fetched_valid_q;
  assign bus.fetched_instruction  = fetched_instruction_q;
  assign bus.fetched_pc           = fetched_pc_q;
  assign bus.halted               = halted_q;

  // Warm-up runs independently of redirects; redirect otherwise overrides capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                 <= WARMUP;
      warm_count            <= '0;
      pc                    <= RESET_PC;
      fetched_valid_q       <= 1'b0;
      fetched_instruction_q <= 32'd0;
      fetched_pc_q          <= 32'd0;
      halted_q              <= 1'b0;
    end else begin
      if (state == WARMUP) begin
        warm_count <= warm_count + 1'b1;
        if (warm_count == WARM_LAST) begin
          state <= FETCH;
        end
      end

      if (bus.redirect_valid) begin
        pc              <= bus.redirect_address;
        fetched_valid_q <= 1'b0;
        if (state == HALTED) begin
          state    <= FETCH;
          halted_q <= 1'b0;
        end
      end else begin
        case (state)
          FETCH: begin
            if (capture_ok) begin
              fetched_instruction_q <= bus.instruction_data_input;
              fetched_pc_q          <= pc;
              fetched_valid_q       <= 1'b1;
              pc                    <= pc + 32'd1;
              if (bus.instruction_data_input[31:27] == HALT_OPCODE) begin
                state    <= HALTED;
                halted_q <= 1'b1;
              end
            end
          end
          HALTED: begin
            if (fetched_valid_q && bus.decode_ready) begin
              fetched_valid_q <= 1'b0;
            end
            if (bus.resume) begin
              state    <= FETCH;
              halted_q <= 1'b0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a scoreboard queue of expected fetch PCs is
// filled as stimulus is driven and drained whenever a new word lands in the fetch register.
module tb_instruction_fetch;
  localparam logic [31:0] HALT_WORD = 32'h3000_0000;

  logic clock;
  logic reset;
  instruction_fetch_if bus ();

  instruction_fetch #(
    .RESET_PC   (32'd0),
    .HALT_OPCODE(5'b00110),
    .START_DELAY(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr == 32'd26) ? HALT_WORD : addr;
  endfunction

  assign bus.instruction_data_input = mem_word(bus.instruction_address);

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshake state before the edge, then pop on any new capture.
  task automatic cycle();
    logic prev_fv, prev_dr;
    logic [31:0] exp_pc;
    prev_fv = bus.fetched_valid;
    prev_dr = bus.decode_ready;
    @(posedge clock);
    #1;
    if (bus.fetched_valid === 1'b1 && (!prev_fv || prev_dr)) begin
      check32("delivery_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_pc = exp_q.pop_front();
        check32("fetched_pc", bus.fetched_pc, exp_pc);
        check32("fetched_instruction", bus.fetched_instruction, mem_word(exp_pc));
      end
    end
  endtask

  task automatic apply_stimulus(input logic rv, input logic [31:0] ra, input logic rs, input logic dr);
    bus.redirect_valid   = rv;
    bus.redirect_address = ra;
    bus.resume           = rs;
    bus.decode_ready     = dr;
  endtask

  task automatic check_reset_values(input string tag);
    check32({tag, "_valid"},  32'(bus.fetched_valid), 32'd0);
    check32({tag, "_addr"},   bus.instruction_address, 32'd0);
    check32({tag, "_halted"}, 32'(bus.halted), 32'd0);
    check32({tag, "_pc"},     bus.fetched_pc, 32'd0);
    check32({tag, "_instr"},  bus.fetched_instruction, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b1);
    #2;
    check_reset_values("reset");
    #10;
    reset = 1'b0;

    // Warm-up: nothing captured on edge 1, first word on edge 2, then one per cycle.
    for (int i = 0; i <= 5; i++) exp_q.push_back(32'(i));
    cycle();
    check32("warmup_valid", 32'(bus.fetched_valid), 32'd0);
    check32("warmup_addr", bus.instruction_address, 32'd0);
    for (int i = 0; i <= 5; i++) begin
      cycle();
      check32("stream_no_gap", 32'(bus.fetched_valid), 32'd1);
    end
    check32("stream_addr", bus.instruction_address, 32'd6);

    // Backpressure for three cycles with PC 5 held in the fetch register.
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check32("bp_pc", bus.fetched_pc, 32'd5);
      check32("bp_addr", bus.instruction_address, 32'd6);
      check32("bp_valid", 32'(bus.fetched_valid), 32'd1);
    end

    // Release and run up to the HALT word at 26.
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b1);
    for (int i = 6; i <= 26; i++) exp_q.push_back(32'(i));
    for (int i = 6; i <= 26; i++) cycle();
    check32("halt_pc", bus.fetched_pc, 32'd26);
    check32("halt_same_edge", 32'(bus.halted), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check32("halted_valid", 32'(bus.fetched_valid), 32'd0);
      check32("halted_addr", bus.instruction_address, 32'd27);
      check32("halted_flag", 32'(bus.halted), 32'd1);
    end

    // Resume: one idle edge, then 27 captured.
    exp_q.push_back(32'd27);
    apply_stimulus(1'b0, 32'd0, 1'b1, 1'b1);
    cycle();
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0);
    check32("resume_halted", 32'(bus.halted), 32'd0);
    cycle();
    check32("resume_pc", bus.fetched_pc, 32'd27);

    // Redirect while holding an unconsumed word.
    cycle();
    check32("hold_pc", bus.fetched_pc, 32'd27);
    apply_stimulus(1'b1, 32'd17, 1'b0, 1'b0);
    cycle();
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0);
    check32("redir_flush", 32'(bus.fetched_valid), 32'd0);
    check32("redir_addr", bus.instruction_address, 32'd17);
    exp_q.push_back(32'd17);
    cycle();
    check32("redir_delivered", 32'(bus.fetched_valid), 32'd1);
    check32("redir_next_addr", bus.instruction_address, 32'd18);

    // Halt again, then redirect together with resume.
    apply_stimulus(1'b1, 32'd25, 1'b0, 1'b1);
    cycle();
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b1);
    exp_q.push_back(32'd25);
    exp_q.push_back(32'd26);
    cycle();
    cycle();
    check32("halt2_flag", 32'(bus.halted), 32'd1);
    apply_stimulus(1'b1, 32'd40, 1'b1, 1'b1);
    cycle();
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b1);
    check32("redir_resume_halted", 32'(bus.halted), 32'd0);
    check32("redir_resume_addr", bus.instruction_address, 32'd40);
    check32("redir_resume_flush", 32'(bus.fetched_valid), 32'd0);
    exp_q.push_back(32'd40);
    cycle();

    // PC wrap from the top of the address space.
    apply_stimulus(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    cycle();
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b1);
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'd0);
    cycle();
    check32("wrap_pc", bus.fetched_pc, 32'hFFFF_FFFF);
    check32("wrap_addr", bus.instruction_address, 32'd0);
    cycle();
    check32("wrap_valid", 32'(bus.fetched_valid), 32'd1);

    // Asynchronous reset between edges mid-stream.
    #3;
    reset = 1'b1;
    #1;
    check_reset_values("async_reset");
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd1);
    cycle();
    check32("rewarm_valid", 32'(bus.fetched_valid), 32'd0);
    cycle();
    cycle();
    check32("rewarm_pc", bus.fetched_pc, 32'd1);
    check32("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
